// File: rtl/micro_sequencer.sv
// micro_sequencer: next-address sequencer for a microprogrammed control unit.
//
// Holds the micro-program counter (upc) and computes its next value each cycle from the
// current microinstruction's seq_op, the selected status bit and the branch/dispatch
// targets. A three-state FSM (IDLE, RUN, ERR) gates sequencing.
//
// Configuration macro: USTACK_EN
//   defined   - CALL/RET use a STACK_DEPTH-entry return stack; overflow/underflow sets
//               the sticky stack_err flag and parks the sequencer in ERR.
//   undefined - no stack; CALL acts as JMP, RET acts as FETCH, stack_err is tied to 0.
//
// Ports:
//   clk           in  1        rising-edge clock
//   rst_n         in  1        asynchronous active-low reset
//   start         in  1        leave IDLE and begin sequencing (ignored elsewhere)
//   stall         in  1        hold all state this cycle
//   status        in  1        selected condition bit
//   seq_op        in  3        next-address operation
//   branch_addr   in  UADDR_W  branch/call target
//   dispatch_addr in  UADDR_W  opcode-mapped entry address
//   upc           out UADDR_W  current micro-program counter
//   running       out 1        high while in RUN
//   stack_err     out 1        sticky stack overflow/underflow flag
module micro_sequencer #(
    parameter int unsigned UADDR_W     = 8,
    parameter int unsigned FETCH_ADDR  = 0,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               status,
    input  logic [2:0]         seq_op,
    input  logic [UADDR_W-1:0] branch_addr,
    input  logic [UADDR_W-1:0] dispatch_addr,
    output logic [UADDR_W-1:0] upc,
    output logic               running,
    output logic               stack_err
);

    if (UADDR_W < 1 || STACK_DEPTH < 1) begin : g_param_check
        $error("micro_sequencer: UADDR_W and STACK_DEPTH must be at least 1");
    end

    localparam logic [UADDR_W-1:0] FetchAddr = UADDR_W'(FETCH_ADDR);

    localparam logic [2:0] OpInc   = 3'd0;
    localparam logic [2:0] OpBrt   = 3'd1;
    localparam logic [2:0] OpBrf   = 3'd2;
    localparam logic [2:0] OpJmp   = 3'd3;
    localparam logic [2:0] OpDisp  = 3'd4;
    localparam logic [2:0] OpCall  = 3'd5;
    localparam logic [2:0] OpRet   = 3'd6;
    localparam logic [2:0] OpFetch = 3'd7;

    typedef enum logic [1:0] {StIdle, StRun, StErr} state_e;

    state_e             state_q, state_d;
    logic [UADDR_W-1:0] upc_q, upc_d;
    logic               running_q, running_d;
    logic [UADDR_W-1:0] upc_inc;

    // Natural wrap at the top of the address space; also the CALL return value.
    assign upc_inc = upc_q + 1'b1;

`ifdef USTACK_EN
    localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [UADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [SpW-1:0]     sp_q, sp_d;
    logic [SpW-1:0]     sp_dec;
    logic               stack_err_q, stack_err_d;
    logic               push_en;
    logic               stack_full;
    logic               stack_empty;

    assign sp_dec      = sp_q - 1'b1;
    assign stack_full  = (sp_q == SpW'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
`endif

    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
`ifdef USTACK_EN
        sp_d        = sp_q;
        stack_err_d = stack_err_q;
        push_en     = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                upc_d = FetchAddr;
                if (start && !stall) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!stall) begin
                    case (seq_op)
                        OpInc:  upc_d = upc_inc;
                        OpBrt:  upc_d = status ? branch_addr : upc_inc;
                        OpBrf:  upc_d = status ? upc_inc : branch_addr;
                        OpJmp:  upc_d = branch_addr;
                        OpDisp: upc_d = dispatch_addr;
                        OpCall: begin
`ifdef USTACK_EN
                            if (stack_full) begin
                                state_d     = StErr;
                                stack_err_d = 1'b1;
                            end else begin
                                push_en = 1'b1;
                                sp_d    = sp_q + 1'b1;
                                upc_d   = branch_addr;
                            end
`else
                            upc_d = branch_addr;
`endif
                        end
                        OpRet: begin
`ifdef USTACK_EN
                            if (stack_empty) begin
                                state_d     = StErr;
                                stack_err_d = 1'b1;
                            end else begin
                                sp_d  = sp_dec;
                                upc_d = stack_q[sp_dec[IdxW-1:0]];
                            end
`else
                            upc_d = FetchAddr;
`endif
                        end
                        OpFetch: begin
                            upc_d = FetchAddr;
`ifdef USTACK_EN
                            sp_d = '0;
`endif
                        end
                        default: upc_d = upc_q;
                    endcase
                end
            end
            StErr: begin
                // Parked until reset.
                state_d = StErr;
            end
            default: state_d = StIdle;
        endcase
        running_d = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            upc_q       <= FetchAddr;
            running_q   <= 1'b0;
`ifdef USTACK_EN
            sp_q        <= '0;
            stack_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            upc_q       <= upc_d;
            running_q   <= running_d;
`ifdef USTACK_EN
            sp_q        <= sp_d;
            stack_err_q <= stack_err_d;
`endif
        end
    end

`ifdef USTACK_EN
    // Stack contents survive reset; only the pointer is cleared.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[sp_q[IdxW-1:0]] <= upc_inc;
        end
    end

    assign stack_err = stack_err_q;
`else
    assign stack_err = 1'b0;
`endif

    assign upc     = upc_q;
    assign running = running_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed cases with literal expectations,
// then randomized stimulus compared every cycle against a queue-based reference model.
module tb_micro_sequencer;

    localparam int unsigned W     = 8;
    localparam int unsigned FA    = 0;
    localparam int unsigned DEPTH = 4;
    localparam int          MASK  = (1 << W) - 1;

    localparam logic [2:0] INC = 3'd0, BRT = 3'd1, BRF = 3'd2, JMP = 3'd3;
    localparam logic [2:0] DSP = 3'd4, CALL = 3'd5, RET = 3'd6, FET = 3'd7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         stall;
    logic         status;
    logic [2:0]   seq_op;
    logic [W-1:0] branch_addr;
    logic [W-1:0] dispatch_addr;
    logic [W-1:0] upc;
    logic         running;
    logic         stack_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int m_upc;
    bit m_run;
    bit m_err;
    int m_stk[$];

    micro_sequencer #(
        .UADDR_W     (W),
        .FETCH_ADDR  (FA),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .status        (status),
        .seq_op        (seq_op),
        .branch_addr   (branch_addr),
        .dispatch_addr (dispatch_addr),
        .upc           (upc),
        .running       (running),
        .stack_err     (stack_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_upc = FA;
        m_run = 1'b0;
        m_err = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_step(input bit st, input bit stl, input logic [2:0] op,
                              input int br, input int disp, input bit sts);
        int nxt;
        if (stl || m_err) return;
        if (!m_run) begin
            if (st) m_run = 1'b1;
            return;
        end
        nxt = (m_upc + 1) & MASK;
        case (op)
            INC: m_upc = nxt;
            BRT: m_upc = sts ? br : nxt;
            BRF: m_upc = sts ? nxt : br;
            JMP: m_upc = br;
            DSP: m_upc = disp;
            CALL: begin
`ifdef USTACK_EN
                if (m_stk.size() == DEPTH) begin
                    m_err = 1'b1;
                    m_run = 1'b0;
                end else begin
                    m_stk.push_back(nxt);
                    m_upc = br;
                end
`else
                m_upc = br;
`endif
            end
            RET: begin
`ifdef USTACK_EN
                if (m_stk.size() == 0) begin
                    m_err = 1'b1;
                    m_run = 1'b0;
                end else begin
                    m_upc = m_stk.pop_back();
                end
`else
                m_upc = FA;
`endif
            end
            default: begin
                m_upc = FA;
                m_stk.delete();
            end
        endcase
    endtask

    task automatic compare_model(input string tag);
        cmp({tag, ".upc"}, int'(upc), m_upc);
        cmp({tag, ".running"}, int'(running), int'(m_run));
        cmp({tag, ".stack_err"}, int'(stack_err), int'(m_err));
    endtask

    // Literal expectation: pins both the DUT and the model.
    task automatic lit(input string nm, input int upc_e, input bit run_e, input bit err_e);
        cmp({nm, ".upc"}, int'(upc), upc_e);
        cmp({nm, ".running"}, int'(running), int'(run_e));
        cmp({nm, ".stack_err"}, int'(stack_err), int'(err_e));
        cmp({nm, ".model_upc"}, m_upc, upc_e);
        cmp({nm, ".model_err"}, int'(m_err), int'(err_e));
    endtask

    task automatic step(input bit st, input bit stl, input logic [2:0] op, input int br,
                        input int disp, input bit sts);
        start         = st;
        stall         = stl;
        seq_op        = op;
        branch_addr   = W'(br);
        dispatch_addr = W'(disp);
        status        = sts;
        @(posedge clk);
        model_step(st, stl, op, br, disp, sts);
        #1;
        compare_model("cyc");
    endtask

    task automatic op1(input logic [2:0] op, input int br);
        step(1'b0, 1'b0, op, br, 0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_model("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic mid_cycle_reset(input string nm);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        lit(nm, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        status = 1'b0;
        seq_op = INC;
        branch_addr = '0;
        dispatch_addr = '0;
        model_reset();
        #2;
        lit("reset", 0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Stall in IDLE holds off start.
        step(1'b1, 1'b1, INC, 0, 0, 1'b0);
        lit("idle_stall", 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, INC, 0, 0, 1'b0);
        lit("start", 0, 1'b1, 1'b0);
        op1(INC, 0); lit("inc1", 1, 1'b1, 1'b0);
        op1(INC, 0); lit("inc2", 2, 1'b1, 1'b0);
        op1(INC, 0); lit("inc3", 3, 1'b1, 1'b0);

        op1(JMP, 5);
        step(1'b0, 1'b0, BRT, 'h40, 0, 1'b1); lit("brt_taken", 'h40, 1'b1, 1'b0);
        op1(JMP, 5);
        step(1'b0, 1'b0, BRT, 'h40, 0, 1'b0); lit("brt_not", 6, 1'b1, 1'b0);
        op1(JMP, 5);
        step(1'b0, 1'b0, BRF, 'h40, 0, 1'b0); lit("brf_taken", 'h40, 1'b1, 1'b0);

        op1(JMP, 'hFF);
        op1(INC, 0); lit("wrap", 0, 1'b1, 1'b0);
        op1(JMP, 'h10);
        step(1'b0, 1'b1, JMP, 'h80, 0, 1'b0); lit("stall1", 'h10, 1'b1, 1'b0);
        step(1'b0, 1'b1, JMP, 'h80, 0, 1'b0); lit("stall2", 'h10, 1'b1, 1'b0);
        step(1'b0, 1'b0, JMP, 'h80, 0, 1'b0); lit("unstall", 'h80, 1'b1, 1'b0);
        step(1'b0, 1'b0, DSP, 0, 'h77, 1'b0); lit("dispatch", 'h77, 1'b1, 1'b0);
        step(1'b1, 1'b0, INC, 0, 0, 1'b0); lit("start_ignored", 'h78, 1'b1, 1'b0);

`ifdef USTACK_EN
        op1(FET, 0); lit("fetch", 0, 1'b1, 1'b0);
        op1(JMP, 'h10);
        op1(CALL, 'h20); lit("call1", 'h20, 1'b1, 1'b0);
        op1(CALL, 'h30); lit("call2", 'h30, 1'b1, 1'b0);
        op1(RET, 0);     lit("ret1", 'h21, 1'b1, 1'b0);
        op1(RET, 0);     lit("ret2", 'h11, 1'b1, 1'b0);
        op1(JMP, 'hFF);
        op1(CALL, 'h40);
        op1(RET, 0);     lit("ret_wrap", 0, 1'b1, 1'b0);
        // FETCH must discard stacked returns.
        op1(CALL, 'h50);
        op1(FET, 0);
        op1(RET, 0);     lit("fetch_clears", 0, 1'b0, 1'b1);
        do_reset();
        step(1'b1, 1'b0, INC, 0, 0, 1'b0);
        op1(JMP, 'h10);
        for (int i = 1; i <= 4; i++) op1(CALL, i);
        lit("nest4", 4, 1'b1, 1'b0);
        op1(CALL, 'h50); lit("overflow", 4, 1'b0, 1'b1);
        step(1'b1, 1'b0, JMP, 'h33, 0, 1'b0); lit("err_frozen", 4, 1'b0, 1'b1);
        do_reset();
        step(1'b1, 1'b0, INC, 0, 0, 1'b0);
        op1(RET, 0); lit("underflow", 0, 1'b0, 1'b1);
        mid_cycle_reset("async_reset");
`else
        op1(JMP, 'h10);
        op1(CALL, 'h20); lit("call_as_jmp", 'h20, 1'b1, 1'b0);
        op1(RET, 0);     lit("ret_as_fetch", FA, 1'b1, 1'b0);
        op1(JMP, 'h33);
        mid_cycle_reset("async_reset");
`endif

        // Randomized phase.
        for (int n = 0; n < 3000; n++) begin
            if (m_err || ($urandom % 150) == 0) begin
                do_reset();
            end
            step(($urandom % 4) == 0, ($urandom % 8) == 0, 3'($urandom % 8),
                 int'($urandom % 256), int'($urandom % 256), 1'($urandom % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
